// File: rtl/cnt_sched_pkg.sv
// Shared types and default widths for the counter job scheduler.
package cnt_sched_pkg;

    localparam int unsigned CNT_WIDTH = 4;
    localparam int unsigned CNT_LENW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/cnt_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module cnt_rr_arb #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IDXW-1:0] win_idx
);

    logic        found;
    int unsigned j;

    always_comb begin
        found   = 1'b0;
        win_oh  = '0;
        win_idx = '0;
        j       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/cnt_job_sched.sv
// Round-robin scheduler sharing one up/down counter among NREQ counting jobs.
// The counter has no enable, so idle/done hold it by reloading its own value.
module cnt_job_sched
    import cnt_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = CNT_WIDTH,
    parameter int unsigned LENW  = CNT_LENW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_start,
    input  logic [NREQ-1:0]       req_down,
    input  logic [NREQ*LENW-1:0]  req_len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  wrap,
    output logic                  busy,
    output logic                  cnt_load_en,
    output logic [WIDTH-1:0]      cnt_load,
    output logic                  cnt_down,
    input  logic [WIDTH-1:0]      cnt_count,
    input  logic                  cnt_rollover
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_t state, state_d;

    logic [IDXW-1:0]  ptr;
    logic [IDXW-1:0]  owner_q;
    logic [WIDTH-1:0] start_q;
    logic             down_q;
    logic [LENW-1:0]  len_q;
    logic [LENW-1:0]  rem;
    logic             wrap_q;

    logic [NREQ-1:0]  win_oh;
    logic [IDXW-1:0]  win_idx;
    logic             any_req;
    logic [IDXW-1:0]  next_ptr;
    logic [WIDTH-1:0] sel_start;
    logic             sel_down;
    logic [LENW-1:0]  sel_len;
    logic             wrap_hit;

    cnt_rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    assign any_req  = |req;
    assign next_ptr = (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + IDXW'(1);
    assign wrap_hit = down_q ? (cnt_count == '0) : cnt_rollover;

    // Mux the winning requester's job fields out of the flat request buses.
    always_comb begin
        sel_start = '0;
        sel_down  = 1'b0;
        sel_len   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                sel_start = req_start[i*WIDTH +: WIDTH];
                sel_down  = req_down[i];
                sel_len   = req_len[i*LENW +: LENW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d     = state;
        gnt         = '0;
        done        = '0;
        result      = '0;
        wrap        = 1'b0;
        busy        = (state != IDLE);
        cnt_load_en = 1'b1;
        cnt_load    = cnt_count;
        cnt_down    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && !rst) begin
                    gnt     = win_oh;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_load = start_q;
                state_d  = (len_q == '0) ? DONE : RUN;
            end
            RUN: begin
                cnt_load_en = 1'b0;
                cnt_down    = down_q;
                if (rem == LENW'(1)) state_d = DONE;
            end
            DONE: begin
                done[owner_q] = 1'b1;
                result        = cnt_count;
                wrap          = wrap_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Job latches, step counter, wrap flag and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            owner_q <= '0;
            start_q <= '0;
            down_q  <= 1'b0;
            len_q   <= '0;
            rem     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        start_q <= sel_start;
                        down_q  <= sel_down;
                        len_q   <= sel_len;
                        owner_q <= win_idx;
                        wrap_q  <= 1'b0;
                        ptr     <= next_ptr;
                    end
                end
                LOAD: rem <= len_q;
                RUN: begin
                    rem <= rem - LENW'(1);
                    if (wrap_hit) wrap_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_job_sched.sv
// Scoreboard bench for cnt_job_sched with a behavioural counter attached.
module tb_cnt_job_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int LENW  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_start = '0;
    logic [NREQ-1:0]       req_down = '0;
    logic [NREQ*LENW-1:0]  req_len = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  wrap;
    logic                  busy;
    logic                  cnt_load_en;
    logic [WIDTH-1:0]      cnt_load;
    logic                  cnt_down;
    logic [WIDTH-1:0]      cnt_count;
    logic                  cnt_rollover;

    typedef struct {
        int         idx;
        logic [3:0] res;
        logic       wrp;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   gnt_log[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   mptr = 0;
    int   next_free = 0;

    cnt_job_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_start    (req_start),
        .req_down     (req_down),
        .req_len      (req_len),
        .gnt          (gnt),
        .done         (done),
        .result       (result),
        .wrap         (wrap),
        .busy         (busy),
        .cnt_load_en  (cnt_load_en),
        .cnt_load     (cnt_load),
        .cnt_down     (cnt_down),
        .cnt_count    (cnt_count),
        .cnt_rollover (cnt_rollover)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared free-running load/up/down counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt_count <= '0;
        else if (cnt_load_en) cnt_count <= cnt_load;
        else if (cnt_down)    cnt_count <= cnt_count - 4'd1;
        else                  cnt_count <= cnt_count + 4'd1;
    end
    assign cnt_rollover = &cnt_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: predicts grants/busy, pushes expected completions, checks done.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_g;
        logic [3:0]      s, l;
        logic            d;
        int              w;
        exp_t            e;
        if (rst) begin
            check("rst_gnt", 32'(gnt), 0);
            check("rst_done", 32'(done), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_wrap", 32'(wrap), 0);
            check("rst_result", 32'(result), 0);
            check("rst_load_en", 32'(cnt_load_en), 1);
            check("rst_load", 32'(cnt_load), 32'(cnt_count));
            check("rst_down", 32'(cnt_down), 0);
            sb.delete();
            mptr = 0;
            next_free = 0;
        end else begin
            exp_g = '0;
            w = -1;
            if (cyc >= next_free && req != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
                end
                exp_g[w] = 1'b1;
            end
            check("gnt", 32'(gnt), 32'(exp_g));
            check("busy", 32'(busy), 32'(cyc < next_free));
            if (w >= 0) begin
                s = req_start[w*WIDTH +: WIDTH];
                d = req_down[w];
                l = req_len[w*LENW +: LENW];
                e.idx = w;
                e.res = d ? s - l : s + l;
                e.wrp = d ? (int'(l) > int'(s)) : (int'(s) + int'(l) >= 16);
                e.due = cyc + int'(l) + 2;
                sb.push_back(e);
                gnt_log.push_back(w);
                mptr = (w + 1) % NREQ;
                next_free = cyc + int'(l) + 3;
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    e = sb.pop_front();
                    check("done_owner", 32'(done), 32'(1) << e.idx);
                    check("result", 32'(result), 32'(e.res));
                    check("wrap", 32'(wrap), 32'(e.wrp));
                    check("done_cycle", 32'(cyc), 32'(e.due));
                end
            end else begin
                check("idle_result", 32'(result), 0);
                check("idle_wrap", 32'(wrap), 0);
            end
        end
    end

    task automatic submit(input int i, input logic [3:0] s, input logic d, input logic [3:0] l);
        int n;
        @(posedge clk); #1;
        req_start[i*WIDTH +: WIDTH] = s;
        req_down[i] = d;
        req_len[i*LENW +: LENW] = l;
        req[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[i] && n < 200);
        check("gnt_seen", 32'(gnt[i]), 1);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || busy) && n < 300);
        check("drain", 32'(sb.size()), 0);
    endtask

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n;

        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 0);

        submit(0, 4'h3, 1'b0, 4'd4);
        wait_idle();
        submit(1, 4'hE, 1'b0, 4'd3);
        wait_idle();
        submit(2, 4'h1, 1'b1, 4'd2);
        wait_idle();

        submit(3, 4'h9, 1'b0, 4'd0);
        wait_idle();
        repeat (10) begin
            @(negedge clk);
            check("hold", 32'(cnt_count), 32'h9);
        end

        // All requesters held high: grants must rotate 0,1,2,3,0.
        gnt_log.delete();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_start[i*WIDTH +: WIDTH] = 4'(i * 3);
            req_down[i] = i[0];
            req_len[i*LENW +: LENW] = 4'd2;
        end
        req = '1;
        n = 0;
        while (gnt_log.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req = '0;
        wait_idle();
        check("fair_count", 32'(gnt_log.size() >= 5), 1);
        for (int i = 0; i < 5; i++) begin
            if (i < gnt_log.size()) check("fair_order", 32'(gnt_log[i]), 32'(exp_order[i]));
        end

        // Reset in the middle of a long job; no completion may follow.
        submit(0, 4'h0, 1'b0, 4'd8);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrun_busy", 32'(busy), 0);
        check("midrun_done", 32'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no_stale_job", 32'(sb.size()), 0);

        @(posedge clk); #1;
        req_start[2*WIDTH +: WIDTH] = 4'h5;
        req_down[2] = 1'b0;
        req_len[2*LENW +: LENW] = 4'd1;
        req_start[3*WIDTH +: WIDTH] = 4'h2;
        req_down[3] = 1'b1;
        req_len[3*LENW +: LENW] = 4'd3;
        req[3:2] = 2'b11;
        @(negedge clk);
        check("rr_after_rst", 32'(gnt), 32'b0100);
        @(posedge clk); #1;
        req[2] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[3] && n < 200);
        check("gnt3_seen", 32'(gnt[3]), 1);
        @(posedge clk); #1;
        req[3] = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
